act_row_feeder: RTL and testbench

//  Controller-side transmitter for the per-row activation handshake of a superblock row.
//  - Accepts one tagged activation stream (2 x WID_ACT per word, destination row index).
//  - Buffers each word in a per-row FIFO.
//  - Drives act_data_in / act_data_in_vld to each row when that row raises act_data_in_req.
//  - Sits between the activation DMA/loader and the N_ROW superblock inputs.

---
 rtl/act_row_feeder_if.sv | 25 ++
 rtl/act_row_feeder.sv | 126 ++++++++++++
 tb/tb_act_row_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_row_feeder_if.sv
// Activation stream (loader side) plus per-row delivery bus of the row feeder.
// master = the feeder itself, slave = the loader/rows environment around it.
interface act_row_feeder_if #(
  parameter int N_ROW   = 10,
  parameter int WID_ACT = 16,
  parameter int WID_ROW = $clog2(N_ROW)
);
  logic [2*WID_ACT-1:0]       src_data;
  logic [WID_ROW-1:0]         src_row;
  logic                       src_vld;
  logic                       src_rdy;
  logic [2*WID_ACT*N_ROW-1:0] act_data_in;
  logic [N_ROW-1:0]           act_data_in_vld;
  logic [N_ROW-1:0]           act_data_in_req;

  modport master (
    input  src_data, src_row, src_vld, act_data_in_req,
    output src_rdy, act_data_in, act_data_in_vld
  );

  modport slave (
    output src_data, src_row, src_vld, act_data_in_req,
    input  src_rdy, act_data_in, act_data_in_vld
  );
endinterface

// File: rtl/act_row_feeder.sv
// Per-row activation feeder: one tagged input stream demuxed into N_ROW FIFOs,
// each row popped independently on its own request with a registered strobe.
module act_row_feeder #(
  parameter int N_ROW      = 10,
  parameter int WID_ACT    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WID_ROW    = $clog2(N_ROW),
  parameter int WID_CNT    = 16
) (
  input  logic                     clk_l,
  input  logic                     rst_n,
  input  logic                     flush,
  act_row_feeder_if.master         bus,
  output logic [WID_CNT*N_ROW-1:0] row_cnt,
  output logic [N_ROW-1:0]         fifo_empty,
  output logic                     err_row,
  output logic                     idle
);
  localparam int WID_W = 2*WID_ACT;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef logic [AW:0] ptr_t;

  logic [WID_W-1:0]   mem_q  [N_ROW][FIFO_DEPTH];
  logic [WID_W-1:0]   mem_d  [N_ROW][FIFO_DEPTH];
  ptr_t               wr_ptr_q [N_ROW];
  ptr_t               wr_ptr_d [N_ROW];
  ptr_t               rd_ptr_q [N_ROW];
  ptr_t               rd_ptr_d [N_ROW];
  logic [WID_W-1:0]   dout_q [N_ROW];
  logic [WID_W-1:0]   dout_d [N_ROW];
  logic [WID_CNT-1:0] cnt_q  [N_ROW];
  logic [WID_CNT-1:0] cnt_d  [N_ROW];
  logic [N_ROW-1:0]   vld_q, vld_d;
  logic               err_q, err_d;

  logic [N_ROW-1:0]   empty, full, pop;
  logic [WID_ROW-1:0] row_idx;
  logic               row_ok, push;

  assign row_idx = bus.src_row;
  assign row_ok  = ({1'b0, row_idx} < (WID_ROW+1)'(N_ROW));

  // Full/empty from the extra pointer MSB: equal low bits, MSB differs -> full.
  always_comb begin
    for (int unsigned r = 0; r < N_ROW; r++) begin
      empty[r] = (wr_ptr_q[r] == rd_ptr_q[r]);
      full[r]  = (wr_ptr_q[r][AW] != rd_ptr_q[r][AW]) &&
                 (wr_ptr_q[r][AW-1:0] == rd_ptr_q[r][AW-1:0]);
      pop[r]   = bus.act_data_in_req[r] & ~empty[r] & ~flush;
    end
  end

  // Out-of-range words are accepted (and dropped) so the stream never stalls on them.
  always_comb begin
    bus.src_rdy = 1'b0;
    if (!flush) bus.src_rdy = row_ok ? ~full[row_idx] : 1'b1;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    vld_d    = '0;
    err_d    = err_q;
    push     = bus.src_vld & bus.src_rdy & row_ok;

    if (push) begin
      mem_d[row_idx][wr_ptr_q[row_idx][AW-1:0]] = bus.src_data;
      wr_ptr_d[row_idx] = wr_ptr_q[row_idx] + ptr_t'(1);
    end
    if (bus.src_vld & bus.src_rdy & ~row_ok) err_d = 1'b1;

    for (int unsigned r = 0; r < N_ROW; r++) begin
      if (pop[r]) begin
        dout_d[r]   = mem_q[r][rd_ptr_q[r][AW-1:0]];
        rd_ptr_d[r] = rd_ptr_q[r] + ptr_t'(1);
        cnt_d[r]    = cnt_q[r] + WID_CNT'(1);
        vld_d[r]    = 1'b1;
      end
    end

    // Flush keeps the delivered slice data; everything else returns to empty.
    if (flush) begin
      wr_ptr_d = '{default: '0};
      rd_ptr_d = '{default: '0};
      cnt_d    = '{default: '0};
      vld_d    = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_l) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      dout_q   <= '{default: '0};
      cnt_q    <= '{default: '0};
      vld_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  for (genvar g = 0; g < N_ROW; g++) begin : g_pack
    assign bus.act_data_in[g*WID_W +: WID_W] = dout_q[g];
    assign row_cnt[g*WID_CNT +: WID_CNT]     = cnt_q[g];
  end

  assign bus.act_data_in_vld = vld_q;
  assign fifo_empty          = empty;
  assign err_row             = err_q;
  assign idle                = (&empty) & ~(|vld_q);
endmodule

// File: tb/tb_act_row_feeder.sv
// Self-checking bench for act_row_feeder: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_act_row_feeder;
  localparam int N_ROW      = 10;
  localparam int WID_ACT    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int WID_ROW    = $clog2(N_ROW);
  localparam int WID_CNT    = 16;

  logic                     clk_l;
  logic                     rst_n;
  logic                     flush;
  logic [WID_CNT*N_ROW-1:0] row_cnt;
  logic [N_ROW-1:0]         fifo_empty;
  logic                     err_row;
  logic                     idle;

  act_row_feeder_if #(.N_ROW(N_ROW), .WID_ACT(WID_ACT), .WID_ROW(WID_ROW)) bus ();

  act_row_feeder #(
    .N_ROW(N_ROW), .WID_ACT(WID_ACT), .FIFO_DEPTH(FIFO_DEPTH),
    .WID_ROW(WID_ROW), .WID_CNT(WID_CNT)
  ) dut (
    .clk_l(clk_l), .rst_n(rst_n), .flush(flush), .bus(bus),
    .row_cnt(row_cnt), .fifo_empty(fifo_empty), .err_row(err_row), .idle(idle)
  );

  initial clk_l = 1'b0;
  always #5 clk_l = ~clk_l;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per row plus the last delivered word per row.
  logic [31:0]        mq [N_ROW][$];
  logic [31:0]        m_data [N_ROW];
  logic [WID_CNT-1:0] m_cnt [N_ROW];
  logic [N_ROW-1:0]   m_vld;
  logic               m_err;

  typedef struct {
    logic               v;
    logic [WID_ROW-1:0] row;
    logic [31:0]        d;
    logic [N_ROW-1:0]   req;
    logic               fl;
    logic               e_rdy;
    logic [N_ROW-1:0]   e_vld;
    logic               e_err;
    logic               e_idle;
  } vec_t;

  vec_t tbl [11];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < N_ROW; r++) begin
      mq[r].delete();
      m_data[r] = '0;
      m_cnt[r]  = '0;
    end
    m_vld = '0;
    m_err = 1'b0;
  endfunction

  function automatic void check_state();
    logic all_empty;
    all_empty = 1'b1;
    chk("vld", 64'(bus.act_data_in_vld), 64'(m_vld));
    for (int r = 0; r < N_ROW; r++) begin
      chk($sformatf("slice[%0d]", r), 64'(bus.act_data_in[r*32 +: 32]), 64'(m_data[r]));
      chk($sformatf("row_cnt[%0d]", r), 64'(row_cnt[r*WID_CNT +: WID_CNT]), 64'(m_cnt[r]));
      chk($sformatf("fifo_empty[%0d]", r), 64'(fifo_empty[r]), 64'(mq[r].size() == 0));
      if (mq[r].size() != 0) all_empty = 1'b0;
    end
    chk("idle", 64'(idle), 64'(all_empty && (m_vld == '0)));
    chk("err_row", 64'(err_row), 64'(m_err));
  endfunction

  // One clock: drive after the edge, check at the falling edge, then advance the model.
  task automatic cycle(input logic v, input logic [WID_ROW-1:0] row, input logic [31:0] d,
                       input logic [N_ROW-1:0] req, input logic fl);
    logic             exp_rdy;
    logic             inr;
    logic [N_ROW-1:0] nv;
    @(posedge clk_l); #1;
    bus.src_vld = v; bus.src_row = row; bus.src_data = d;
    bus.act_data_in_req = req; flush = fl;
    @(negedge clk_l);
    inr     = (int'(row) < N_ROW);
    exp_rdy = !fl && (!inr || mq[row].size() < FIFO_DEPTH);
    chk("src_rdy", 64'(bus.src_rdy), 64'(exp_rdy));
    check_state();
    nv = '0;
    if (fl) begin
      for (int r = 0; r < N_ROW; r++) begin
        mq[r].delete();
        m_cnt[r] = '0;
      end
      m_err = 1'b0;
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (req[r] && mq[r].size() > 0) begin
          m_data[r] = mq[r].pop_front();
          m_cnt[r]  = m_cnt[r] + 1'b1;
          nv[r]     = 1'b1;
        end
      end
      if (v && exp_rdy) begin
        if (inr) mq[row].push_back(d);
        else     m_err = 1'b1;
      end
    end
    m_vld = nv;
  endtask

  task automatic idle_cyc(input logic [N_ROW-1:0] req);
    cycle(1'b0, '0, '0, req, 1'b0);
  endtask

  task automatic do_flush();
    cycle(1'b0, '0, '0, '0, 1'b1);
  endtask

  int unsigned cnt4;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus.src_vld = 1'b0; bus.src_row = '0; bus.src_data = '0; bus.act_data_in_req = '0;
    model_reset();
    repeat (2) @(negedge clk_l);
    chk("rst src_rdy", 64'(bus.src_rdy), 64'(1));
    chk("rst fifo_empty", 64'(fifo_empty), 64'(10'h3FF));
    chk("rst idle", 64'(idle), 64'(1));
    chk("rst vld", 64'(bus.act_data_in_vld), 64'(0));
    chk("rst row_cnt", 64'(row_cnt[63:0]), 64'(0));
    rst_n = 1'b1;

    // Vector table from reset: inputs of a cycle, outputs seen in that same cycle.
    tbl[0]  = '{1'b1, 4'd3,  32'hAAAA_5555, 10'h000, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 4'd3,  32'h0,         10'h008, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'd3,  32'h0,         10'h008, 1'b0, 1'b1, 10'h008, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd12, 32'h1234_5678, 10'h000, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'd12, 32'h0,         10'h000, 1'b0, 1'b1, 10'h000, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 4'd0,  32'hDEAD_0000, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 4'd0,  32'h0,         10'h000, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 4'd0,  32'hBBBB_CCCC, 10'h001, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'd0,  32'h0,         10'h001, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,         10'h001, 1'b0, 1'b1, 10'h001, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'd0,  32'h0,         10'h001, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].row, tbl[i].d, tbl[i].req, tbl[i].fl);
      chk($sformatf("tbl%0d rdy", i), 64'(bus.src_rdy), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d vld", i), 64'(bus.act_data_in_vld), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d err", i), 64'(err_row), 64'(tbl[i].e_err));
      chk($sformatf("tbl%0d idle", i), 64'(idle), 64'(tbl[i].e_idle));
    end

    // Single word to row 3: strobe two cycles after accept, exactly once.
    do_flush();
    cycle(1'b1, 4'd3, 32'hAAAA_5555, 10'h008, 1'b0);
    idle_cyc(10'h008);
    idle_cyc(10'h008);
    chk("t1 vld", 64'(bus.act_data_in_vld), 64'(10'h008));
    chk("t1 slice", 64'(bus.act_data_in[3*32 +: 32]), 64'(32'hAAAA_5555));
    chk("t1 cnt", 64'(row_cnt[3*WID_CNT +: WID_CNT]), 64'(1));
    idle_cyc(10'h008);
    chk("t1 once", 64'(bus.act_data_in_vld), 64'(0));

    // Fill row 0, fifth push stalls, then drain back-to-back in order.
    do_flush();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd0, 32'h100 + 32'(i), 10'h000, 1'b0);
    cycle(1'b1, 4'd0, 32'h104, 10'h000, 1'b0);
    chk("t2 full rdy", 64'(bus.src_rdy), 64'(0));
    cycle(1'b0, 4'd0, 32'h0, 10'h001, 1'b0);
    chk("t2 full+pop rdy", 64'(bus.src_rdy), 64'(0));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'd0, 32'h0, 10'h001, 1'b0);
      chk($sformatf("t2 vld%0d", i), 64'(bus.act_data_in_vld[0]), 64'(1));
      chk($sformatf("t2 data%0d", i), 64'(bus.act_data_in[31:0]), 64'(32'h100 + 32'(i)));
      if (i == 0) chk("t2 rdy back", 64'(bus.src_rdy), 64'(1));
    end

    // Rows 1 and 9 interleaved.
    do_flush();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, (i % 2 == 0) ? 4'd1 : 4'd9, 32'h1000 + 32'(i), 10'h202, 1'b0);
    repeat (3) idle_cyc(10'h202);
    chk("t3 cnt1", 64'(row_cnt[1*WID_CNT +: WID_CNT]), 64'(4));
    chk("t3 cnt9", 64'(row_cnt[9*WID_CNT +: WID_CNT]), 64'(4));

    // Out-of-range row: dropped, sticky error until flush.
    do_flush();
    cycle(1'b1, 4'd12, 32'hCAFE_F00D, 10'h3FF, 1'b0);
    repeat (3) idle_cyc(10'h3FF);
    chk("t4 err", 64'(err_row), 64'(1));
    chk("t4 no vld", 64'(bus.act_data_in_vld), 64'(0));
    do_flush();
    idle_cyc('0);
    chk("t4 err clr", 64'(err_row), 64'(0));

    // Flush with words pending on rows 2 and 5.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'd2, 32'h2000 + 32'(i), 10'h000, 1'b0);
      cycle(1'b1, 4'd5, 32'h5000 + 32'(i), 10'h000, 1'b0);
    end
    cycle(1'b0, 4'd0, 32'h0, 10'h024, 1'b1);
    idle_cyc(10'h024);
    chk("t5 empty", 64'(fifo_empty), 64'(10'h3FF));
    chk("t5 cnt", 64'(row_cnt), 64'(0));
    chk("t5 idle", 64'(idle), 64'(1));
    chk("t5 vld", 64'(bus.act_data_in_vld), 64'(0));

    // Row 4 drops req mid-stream: one slack word, then nothing until req returns.
    do_flush();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd4, 32'h4000 + 32'(i), 10'h000, 1'b0);
    idle_cyc(10'h010);
    idle_cyc(10'h010);
    cnt4 = 0;
    for (int i = 0; i < 3; i++) begin
      idle_cyc(10'h000);
      if (bus.act_data_in_vld[4]) cnt4++;
    end
    chk("t6 slack vld", 64'(cnt4), 64'(1));
    repeat (4) idle_cyc(10'h010);
    chk("t6 cnt4", 64'(row_cnt[4*WID_CNT +: WID_CNT]), 64'(4));

    // Asynchronous reset while words are streaming.
    cycle(1'b1, 4'd11, 32'h0, 10'h000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'd7, 32'h7000 + 32'(i), 10'h080, 1'b0);
    @(posedge clk_l); #1;
    bus.src_vld = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst vld", 64'(bus.act_data_in_vld), 64'(0));
    chk("arst empty", 64'(fifo_empty), 64'(10'h3FF));
    chk("arst idle", 64'(idle), 64'(1));
    chk("arst err", 64'(err_row), 64'(0));
    chk("arst cnt", 64'(row_cnt), 64'(0));
    chk("arst data", 64'(bus.act_data_in[7*32 +: 32]), 64'(0));
    chk("arst rdy", 64'(bus.src_rdy), 64'(1));
    model_reset();
    @(negedge clk_l);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic               v, fl;
      logic [WID_ROW-1:0] row;
      logic [31:0]        d;
      logic [N_ROW-1:0]   req;
      v   = 1'($urandom_range(0, 1));
      row = WID_ROW'($urandom_range(0, 11));
      d   = $urandom;
      fl  = ($urandom_range(0, 63) == 0);
      for (int r = 0; r < N_ROW; r++) req[r] = ($urandom_range(0, 9) < 6);
      cycle(v, row, d, req, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
